// File: rtl/rsv_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : rsv_gen_if
// Description : Dispatch, CDB broadcast, issue and flush bundle for the
//               reservation station. master = decoder/ROB/EU side,
//               slave = reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
interface rsv_gen_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 8,
  parameter int CDB_N  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    disp_valid;
  logic                    disp_ready;
  logic [OP_W-1:0]         disp_op;
  logic [TAG_W-1:0]        disp_rob;
  logic                    disp_s1_rdy;
  logic [TAG_W-1:0]        disp_s1_tag;
  logic [DATA_W-1:0]       disp_s1_data;
  logic                    disp_s2_rdy;
  logic [TAG_W-1:0]        disp_s2_tag;
  logic [DATA_W-1:0]       disp_s2_data;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*DATA_W-1:0] cdb_data;
  logic                    iss_valid;
  logic                    iss_ready;
  logic [OP_W-1:0]         iss_op;
  logic [TAG_W-1:0]        iss_rob;
  logic [DATA_W-1:0]       iss_a;
  logic [DATA_W-1:0]       iss_b;
  logic                    flush;
  logic [CNT_W-1:0]        count;

  modport master (
    output disp_valid, disp_op, disp_rob,
    output disp_s1_rdy, disp_s1_tag, disp_s1_data,
    output disp_s2_rdy, disp_s2_tag, disp_s2_data,
    output cdb_valid, cdb_tag, cdb_data,
    output iss_ready, flush,
    input  disp_ready, iss_valid, iss_op, iss_rob, iss_a, iss_b, count
  );

  modport slave (
    input  disp_valid, disp_op, disp_rob,
    input  disp_s1_rdy, disp_s1_tag, disp_s1_data,
    input  disp_s2_rdy, disp_s2_tag, disp_s2_data,
    input  cdb_valid, cdb_tag, cdb_data,
    input  iss_ready, flush,
    output disp_ready, iss_valid, iss_op, iss_rob, iss_a, iss_b, count
  );
endinterface
`default_nettype wire

// File: rtl/rsv_gen.sv
`default_nettype none
// ============================================================================
// Module      : rsv_gen
// Description : Reservation station. Holds DEPTH dispatched instructions,
//               snoops CDB_N result buses for missing operands and issues
//               the oldest operand-ready entry over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rsv_gen #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 8,
  parameter int CDB_N  = 2
) (
  input  logic      clk,
  input  logic      rst,
  rsv_gen_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry storage
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  s1_rdy;
  logic [DEPTH-1:0]  s2_rdy;
  logic [OP_W-1:0]   op_q    [DEPTH];
  logic [TAG_W-1:0]  rob_q   [DEPTH];
  logic [TAG_W-1:0]  s1_tag  [DEPTH];
  logic [TAG_W-1:0]  s2_tag  [DEPTH];
  logic [DATA_W-1:0] s1_data [DEPTH];
  logic [DATA_W-1:0] s2_data [DEPTH];
  // older[j][i] = 1 means entry j was dispatched before entry i
  logic [DEPTH-1:0]  older   [DEPTH];

  logic [CNT_W-1:0]  count_q;
  logic              disp_ready_q;
  // Once an entry is presented and stalled it stays selected until taken
  logic              locked;
  logic [IDX_W-1:0]  lock_idx;

  // Combinational
  logic              s1_wake  [DEPTH];
  logic              s2_wake  [DEPTH];
  logic [DATA_W-1:0] s1_wdata [DEPTH];
  logic [DATA_W-1:0] s2_wdata [DEPTH];
  logic              d1_hit, d2_hit;
  logic [DATA_W-1:0] d1_cdb, d2_cdb;
  logic [DEPTH-1:0]  ready_vec;
  logic              is_oldest;
  logic              sel_any;
  logic [IDX_W-1:0]  sel_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              iss_valid_w;
  logic              iss_fire;
  logic              disp_fire;
  logic [CNT_W-1:0]  count_next;

  // Tag lookup across all buses; the lowest bus index wins on multiple hits
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]        tag,
    input logic [CDB_N-1:0]        v,
    input logic [CDB_N*TAG_W-1:0]  t,
    input logic [CDB_N*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int b = CDB_N - 1; b >= 0; b--) begin
      if (v[b] && (t[b*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, d[b*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  for (genvar i = 0; i < DEPTH; i++) begin : g_wake
    assign {s1_wake[i], s1_wdata[i]} = cdb_match(s1_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    assign {s2_wake[i], s2_wdata[i]} = cdb_match(s2_tag[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  assign {d1_hit, d1_cdb} = cdb_match(bus.disp_s1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  assign {d2_hit, d2_cdb} = cdb_match(bus.disp_s2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

  assign ready_vec = valid & s1_rdy & s2_rdy;

  // Issue select: locked entry if stalled, else the oldest fully-ready entry
  always_comb begin
    sel_any   = 1'b0;
    sel_idx   = '0;
    is_oldest = 1'b0;
    if (locked) begin
      sel_any = 1'b1;
      sel_idx = lock_idx;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        is_oldest = ready_vec[i];
        for (int j = 0; j < DEPTH; j++) begin
          if (ready_vec[j] && older[j][i]) is_oldest = 1'b0;
        end
        if (is_oldest) begin
          sel_any = 1'b1;
          sel_idx = IDX_W'(i);
        end
      end
    end
  end

  // Lowest-index free slot for dispatch
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign iss_valid_w = sel_any && !bus.flush;
  assign iss_fire    = iss_valid_w && bus.iss_ready;
  assign disp_fire   = bus.disp_valid && disp_ready_q && free_found && !bus.flush;

  // Occupancy after this cycle's dispatch/issue
  always_comb begin
    count_next = count_q;
    if (disp_fire && !iss_fire)      count_next = count_q + CNT_W'(1);
    else if (!disp_fire && iss_fire) count_next = count_q - CNT_W'(1);
  end

  // Entry, occupancy and issue-lock state
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid        <= '0;
      count_q      <= '0;
      disp_ready_q <= 1'b1;
      locked       <= 1'b0;
      lock_idx     <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && !s1_rdy[i] && s1_wake[i]) begin
          s1_rdy[i]  <= 1'b1;
          s1_data[i] <= s1_wdata[i];
        end
        if (valid[i] && !s2_rdy[i] && s2_wake[i]) begin
          s2_rdy[i]  <= 1'b1;
          s2_data[i] <= s2_wdata[i];
        end
      end
      if (iss_fire) valid[sel_idx] <= 1'b0;
      if (disp_fire) begin
        valid[free_idx]   <= 1'b1;
        op_q[free_idx]    <= bus.disp_op;
        rob_q[free_idx]   <= bus.disp_rob;
        s1_tag[free_idx]  <= bus.disp_s1_tag;
        s2_tag[free_idx]  <= bus.disp_s2_tag;
        s1_rdy[free_idx]  <= bus.disp_s1_rdy || d1_hit;
        s2_rdy[free_idx]  <= bus.disp_s2_rdy || d2_hit;
        s1_data[free_idx] <= bus.disp_s1_rdy ? bus.disp_s1_data : d1_cdb;
        s2_data[free_idx] <= bus.disp_s2_rdy ? bus.disp_s2_data : d2_cdb;
        for (int j = 0; j < DEPTH; j++) begin
          older[free_idx][j] <= 1'b0;
          older[j][free_idx] <= valid[j];
        end
      end
      count_q      <= count_next;
      disp_ready_q <= (count_next < CNT_W'(DEPTH));
      locked       <= iss_valid_w && !bus.iss_ready;
      lock_idx     <= sel_idx;
    end
  end

  assign bus.disp_ready = disp_ready_q;
  assign bus.count      = count_q;
  assign bus.iss_valid  = iss_valid_w;
  assign bus.iss_op     = sel_any ? op_q[sel_idx]    : '0;
  assign bus.iss_rob    = sel_any ? rob_q[sel_idx]   : '0;
  assign bus.iss_a      = sel_any ? s1_data[sel_idx] : '0;
  assign bus.iss_b      = sel_any ? s2_data[sel_idx] : '0;
endmodule
`default_nettype wire

// File: doc/rsv_gen.md
# rsv_gen

Parametrised reservation station for the Kathryn-I out-of-order core; next generation of the per-unit reservation stations. It sits between the decoder/rename stage and one execution unit. It holds up to DEPTH dispatched instructions and captures source operands broadcast on CDB_N result buses. It issues the oldest operand-ready entry through a valid/ready handshake, so multi-cycle units (e.g. divider) can stall it. A flush from the ROB empties it.

## Interface
- DEPTH, 4: entry count (2..16).
- DATA_W, 32: operand/result width.
- TAG_W, 4: ROB tag width.
- OP_W, 8: opcode/control field width, carried opaquely.
- CDB_N, 2: number of result broadcast buses.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- disp_valid  in  1  decoder offers an instruction.
- disp_ready  out  1  entry free; registered, high iff count < DEPTH.
- disp_op  in  OP_W  opcode/control.
- disp_rob  in  TAG_W  destination ROB tag.
- disp_s1_rdy, disp_s2_rdy  in  1 each  source already available.
- disp_s1_tag, disp_s2_tag  in  TAG_W each  producer tag when not ready.
- disp_s1_data, disp_s2_data  in  DATA_W each  value when ready.
- cdb_valid  in  CDB_N  per-bus broadcast valid.
- cdb_tag  in  CDB_N*TAG_W  bus i at bits [i*TAG_W +: TAG_W].
- cdb_data  in  CDB_N*DATA_W  bus i at bits [i*DATA_W +: DATA_W].
- iss_valid  out  1  an operand-ready entry is presented.
- iss_ready  in  1  execution unit accepts (low while busy).
- iss_op, iss_rob, iss_a, iss_b  out  OP_W/TAG_W/DATA_W/DATA_W  issued fields.
- flush  in  1  ROB mispredict/exception flush.
- count  out  $clog2(DEPTH+1)  occupied entries, registered.

## Operation
- Entry state: valid, op, rob, per source {rdy, tag, data}, age ordering.
- Dispatch: disp_valid && disp_ready && !flush writes the lowest-index free entry.
- Wakeup: each cycle, every valid entry source with rdy=0 compares its tag against all buses with cdb_valid=1. On a match it latches the data and sets rdy.
- Dispatch bypass: a source dispatched with rdy=0 is also compared against the CDB in the dispatch cycle. On a match it is written as ready with the CDB data.
- Multiple buses matching one tag: lowest bus index wins. The producer guarantees the data is identical.
- Issue select: among valid entries with both sources ready, choose the oldest by dispatch order (age matrix or sequence stamp); ties are impossible. iss_* are combinational from the selected entry.
- Handshake: iss_valid && iss_ready frees the entry at the edge. iss_* fields are held stable while iss_valid=1 and iss_ready=0, unless a flush occurs. An older entry becoming ready may not displace a presented entry until it is accepted.
- Flush: all entries are invalidated at the edge. count becomes 0. Dispatch and issue are suppressed in the flush cycle (iss_valid forced 0).
- count: +1 on dispatch, −1 on issue; both in one cycle leaves it unchanged.
- Reset: all entries invalid. count=0, disp_ready=1, iss_valid=0, iss_* = 0.

## Timing
- Dispatch to earliest issue: 1 cycle (entry written at edge N, iss_valid at cycle N+1 if both sources ready).
- CDB wakeup to issue eligibility: 1 cycle. No same-cycle CDB to issue forwarding.
- disp_ready is registered. A slot freed by issue in cycle N becomes visible as disp_ready in cycle N+1; no same-cycle reuse.
- Full: count=DEPTH forces disp_ready=0. disp_valid is ignored and no state changes.
- Empty: iss_valid=0 and iss_* hold last-driven values or 0. Verification checks fields only when iss_valid=1.
- Flush concurrent with dispatch, issue or CDB: flush wins, giving an empty station next cycle.
- rst asserted mid-operation: identical to reset state next cycle, regardless of other inputs.

## Test plan
- Reset, then dispatch op=0x11 rob=3 with both sources ready (a=5, b=7), iss_ready=1 -> iss_valid next cycle with rob=3, a=5, b=7; count 1 then 0.
- Dispatch rob=1 waiting on s1 tag=9. Two cycles later cdb_valid[1]=1, tag=9, data=0xDEAD -> issue one cycle after the broadcast with a=0xDEAD.
- Dispatch waiting on tag=4 while the same cycle carries CDB tag=4 data=0x55 -> entry captured ready; issues next cycle with a=0x55.
- DEPTH=4: dispatch 4 entries waiting on tags 1..4 -> disp_ready=0, count=4. Broadcast tags 3 then 1 with iss_ready=1 -> rob of tag-3 entry issues first, then tag-1 entry; oldest-ready order is checked when both are ready.
- Hold iss_ready=0 for 5 cycles with 2 ready entries (div busy) -> iss_* stable, same oldest rob. Release -> entries issue on consecutive cycles.
- Fill 3 entries, assert flush together with disp_valid and a matching CDB -> count=0, iss_valid=0 next cycle; the dispatched instruction is not stored.
